// File: rtl/acc_requant_drain.sv
// acc_requant_drain: captures final accumulator sums, requantizes them to
// int8 with the TFLM fixed-point scheme (saturating rounding doubling
// high-multiply, rounding right shift, zero-point add, activation clamp) and
// buffers the results in a small FIFO behind a valid/ready port that also
// flags the last element of each tile.
//
// The datapath arithmetic is written for a 32-bit accumulator and 8-bit output.

module acc_requant_drain #(
  parameter int ACC_WIDTH      = 32,
  parameter int OUT_WIDTH      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TILE_LEN_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_i,
  input  logic [ACC_WIDTH-1:0]      acc_data_i,
  input  logic                      acc_valid_i,
  input  logic                      acc_done_i,
  input  logic [31:0]               cfg_multiplier_i,
  input  logic [5:0]                cfg_shift_i,
  input  logic [7:0]                cfg_out_zp_i,
  input  logic [7:0]                cfg_act_min_i,
  input  logic [7:0]                cfg_act_max_i,
  input  logic [TILE_LEN_WIDTH-1:0] cfg_tile_len_i,
  output logic [OUT_WIDTH-1:0]      out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      out_last_o,
  output logic                      overflow_o,
  output logic                      busy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic signed [63:0] INT32_MAX_W = 64'sd2147483647;
  localparam logic signed [63:0] INT32_MIN_W = -64'sd2147483648;
  localparam logic signed [63:0] NUDGE_POS   = 64'sd1073741824;
  localparam logic signed [63:0] NUDGE_NEG   = -64'sd1073741823;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic               s1_valid_q;
  logic signed [31:0] s1_x_q, s1_x_d;
  logic signed [31:0] s1_m_q;
  logic [4:0]         s1_e_q, s1_e_d;

  logic               s2_valid_q;
  logic signed [31:0] s2_y_q, s2_y_d;
  logic [4:0]         s2_e_q;

  logic               s3_valid_q;
  logic [OUT_WIDTH-1:0] s3_data_q, s3_data_d;

  // ---------------------------------------------------------------------------
  // FIFO and tile state
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W:0]            wr_ptr_q, rd_ptr_q;
  logic                      overflow_q;
  logic [TILE_LEN_WIDTH-1:0] cnt_q;

  logic capture;
  logic fifo_empty, fifo_full;
  logic pop, push, drop;
  logic [TILE_LEN_WIDTH-1:0] tile_last_idx;
  logic                      head_last;

  assign capture = acc_valid_i && acc_done_i;

  // ---------------------------------------------------------------------------
  // S1 combinational: saturating left shift and right-shift amount extraction
  // ---------------------------------------------------------------------------
  logic [4:0]         lsh;
  logic signed [63:0] acc_wide, acc_shl;

  // Split the signed shift into left/right parts and saturate the left shift.
  always_comb begin
    lsh      = cfg_shift_i[5] ? 5'd0 : cfg_shift_i[4:0];
    s1_e_d   = cfg_shift_i[5] ? 5'(6'd0 - cfg_shift_i) : 5'd0;
    acc_wide = {{32{acc_data_i[31]}}, acc_data_i[31:0]};
    acc_shl  = acc_wide <<< lsh;
    if (acc_shl > INT32_MAX_W) begin
      s1_x_d = 32'sh7FFFFFFF;
    end else if (acc_shl < INT32_MIN_W) begin
      s1_x_d = 32'sh80000000;
    end else begin
      s1_x_d = acc_shl[31:0];
    end
  end

  // ---------------------------------------------------------------------------
  // S2 combinational: saturating rounding doubling high multiply
  // ---------------------------------------------------------------------------
  logic signed [63:0] x_ext, m_ext, ab, ab_nudged;
  logic               trunc_fix;

  // Product plus nudge, then a divide by 2^31 that truncates toward zero.
  always_comb begin
    x_ext     = {{32{s1_x_q[31]}}, s1_x_q};
    m_ext     = {{32{s1_m_q[31]}}, s1_m_q};
    ab        = x_ext * m_ext;
    ab_nudged = ab + (ab[63] ? NUDGE_NEG : NUDGE_POS);
    trunc_fix = ab_nudged[63] && (ab_nudged[30:0] != 31'd0);
    if ((s1_x_q == 32'sh80000000) && (s1_m_q == 32'sh80000000)) begin
      s2_y_d = 32'sh7FFFFFFF;
    end else begin
      s2_y_d = ab_nudged[62:31] + {31'd0, trunc_fix};
    end
  end

  // ---------------------------------------------------------------------------
  // S3 combinational: rounding divide by power of two, zero point, clamp
  // ---------------------------------------------------------------------------
  logic [31:0]        mask, rem, thr;
  logic signed [31:0] shr, r;
  logic signed [32:0] v, act_min, act_max;

  // Round-half-away-from-zero right shift followed by offset and clamp.
  always_comb begin
    mask    = (32'd1 << s2_e_q) - 32'd1;
    rem     = s2_y_q & mask;
    thr     = (mask >> 1) + {31'd0, s2_y_q[31]};
    shr     = s2_y_q >>> s2_e_q;
    r       = shr + ((rem > thr) ? 32'sd1 : 32'sd0);
    v       = {r[31], r} + {{25{cfg_out_zp_i[7]}}, cfg_out_zp_i};
    act_min = {{25{cfg_act_min_i[7]}}, cfg_act_min_i};
    act_max = {{25{cfg_act_max_i[7]}}, cfg_act_max_i};
    if (v < act_min) begin
      s3_data_d = act_min[OUT_WIDTH-1:0];
    end else if (v > act_max) begin
      s3_data_d = act_max[OUT_WIDTH-1:0];
    end else begin
      s3_data_d = v[OUT_WIDTH-1:0];
    end
  end

  // Three-stage requantization pipeline; only done samples enter it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_m_q     <= '0;
      s1_e_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_e_q     <= '0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
    end else if (clear_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= capture;
      s1_x_q     <= s1_x_d;
      s1_m_q     <= cfg_multiplier_i;
      s1_e_q     <= s1_e_d;
      s2_valid_q <= s1_valid_q;
      s2_y_q     <= s2_y_d;
      s2_e_q     <= s1_e_q;
      s3_valid_q <= s2_valid_q;
      s3_data_q  <= s3_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = !fifo_empty && out_ready_i && !clear_i;
  assign push       = s3_valid_q && (!fifo_full || pop) && !clear_i;
  assign drop       = s3_valid_q && fifo_full && !pop && !clear_i;

  // Storage array; a push into a full FIFO lands in the slot being popped.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= s3_data_q;
    end
  end

  // Pointer, sticky overflow and tile counter bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else if (clear_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        cnt_q    <= head_last ? '0 : cnt_q + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // A tile length of zero behaves like a tile of one element.
  assign tile_last_idx = (cfg_tile_len_i == '0) ? '0 : cfg_tile_len_i - 1'b1;
  assign head_last     = !fifo_empty && (cnt_q == tile_last_idx);

  assign out_valid_o = !fifo_empty;
  assign out_data_o  = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign out_last_o  = head_last;
  assign overflow_o  = overflow_q;
  assign busy_o      = s1_valid_q || s2_valid_q || s3_valid_q || !fifo_empty;

endmodule

// File: tb/tb_acc_requant_drain.sv
// Directed testbench for acc_requant_drain: hand-computed requantization
// vectors, latency, done filtering, backpressure/overflow and tile marking.

module tb_acc_requant_drain;

  logic        clk;
  logic        rst_n;
  logic        clear_i;
  logic [31:0] acc_data_i;
  logic        acc_valid_i;
  logic        acc_done_i;
  logic [31:0] cfg_multiplier_i;
  logic [5:0]  cfg_shift_i;
  logic [7:0]  cfg_out_zp_i;
  logic [7:0]  cfg_act_min_i;
  logic [7:0]  cfg_act_max_i;
  logic [15:0] cfg_tile_len_i;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_last_o;
  logic        overflow_o;
  logic        busy_o;

  int compCount;
  int failCount;

  acc_requant_drain #(
    .ACC_WIDTH(32),
    .OUT_WIDTH(8),
    .FIFO_DEPTH(4),
    .TILE_LEN_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear_i(clear_i),
    .acc_data_i(acc_data_i),
    .acc_valid_i(acc_valid_i),
    .acc_done_i(acc_done_i),
    .cfg_multiplier_i(cfg_multiplier_i),
    .cfg_shift_i(cfg_shift_i),
    .cfg_out_zp_i(cfg_out_zp_i),
    .cfg_act_min_i(cfg_act_min_i),
    .cfg_act_max_i(cfg_act_max_i),
    .cfg_tile_len_i(cfg_tile_len_i),
    .out_data_o(out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_last_o(out_last_o),
    .overflow_o(overflow_o),
    .busy_o(busy_o)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge so outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one accumulator beat.
  task automatic applyStimulus(input logic [31:0] acc, input logic valid, input logic done);
    acc_data_i  = acc;
    acc_valid_i = valid;
    acc_done_i  = done;
  endtask

  // One comparison: count it, and report tag/observed/expected when it fails.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Push one final sum through an idle pipeline, check latency and value, then pop it.
  task automatic runOne(input string tag, input logic [31:0] acc, input logic [7:0] expData);
    applyStimulus(acc, 1'b1, 1'b1);
    step();
    applyStimulus(32'd0, 1'b0, 1'b0);
    step();
    step();
    checkOutput({tag, "_notyet"}, {31'd0, out_valid_o}, 32'd0);
    step();
    checkOutput({tag, "_valid"}, {31'd0, out_valid_o}, 32'd1);
    checkOutput({tag, "_data"}, {24'd0, out_data_o}, {24'd0, expData});
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    checkOutput({tag, "_drained"}, {31'd0, busy_o}, 32'd0);
  endtask

  // Linear sequence of directed steps.
  initial begin
    compCount        = 0;
    failCount        = 0;
    rst_n            = 1'b0;
    clear_i          = 1'b0;
    out_ready_i      = 1'b0;
    applyStimulus(32'd0, 1'b0, 1'b0);
    cfg_multiplier_i = 32'h40000000;
    cfg_shift_i      = 6'd0;
    cfg_out_zp_i     = 8'd0;
    cfg_act_min_i    = 8'h80;
    cfg_act_max_i    = 8'h7F;
    cfg_tile_len_i   = 16'd1;

    // Reset state.
    #3;
    checkOutput("rst_valid", {31'd0, out_valid_o}, 32'd0);
    checkOutput("rst_data", {24'd0, out_data_o}, 32'd0);
    checkOutput("rst_last", {31'd0, out_last_o}, 32'd0);
    checkOutput("rst_ovf", {31'd0, overflow_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic scaling: 100 * 0.5 -> 50, visible four cycles after capture.
    applyStimulus(32'd100, 1'b1, 1'b1);
    step();
    applyStimulus(32'd0, 1'b0, 1'b0);
    checkOutput("basic_busy_s1", {31'd0, busy_o}, 32'd1);
    step();
    step();
    checkOutput("basic_cyc3_valid", {31'd0, out_valid_o}, 32'd0);
    step();
    checkOutput("basic_cyc4_valid", {31'd0, out_valid_o}, 32'd1);
    checkOutput("basic_data", {24'd0, out_data_o}, 32'd50);
    checkOutput("basic_last", {31'd0, out_last_o}, 32'd1);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    checkOutput("basic_pop_valid", {31'd0, out_valid_o}, 32'd0);
    checkOutput("basic_pop_busy", {31'd0, busy_o}, 32'd0);

    // Rounding right shift: m ~ 1.0, shift -2.
    cfg_multiplier_i = 32'h7FFFFFFF;
    cfg_shift_i      = 6'h3E;
    cfg_out_zp_i     = 8'd5;
    runOne("rdbpot_neg", 32'hFFFFFFF6, 8'd2);
    cfg_out_zp_i     = 8'd0;
    runOne("rdbpot_pos", 32'd10, 8'd3);

    // Saturation paths.
    cfg_multiplier_i = 32'h80000000;
    cfg_shift_i      = 6'd0;
    cfg_act_max_i    = 8'd100;
    runOne("srdhm_sat", 32'h80000000, 8'd100);
    cfg_multiplier_i = 32'h40000000;
    cfg_shift_i      = 6'd30;
    runOne("lsh_sat_pos", 32'd1000, 8'd100);
    runOne("lsh_sat_neg", 32'hFFFFFC18, 8'h80);

    // Done filter: only the fourth back-to-back beat is a final sum.
    cfg_shift_i   = 6'd0;
    cfg_act_max_i = 8'h7F;
    for (int i = 0; i < 4; i++) begin
      applyStimulus((i == 3) ? 32'd100 : 32'(7 + i), 1'b1, (i == 3));
      step();
    end
    applyStimulus(32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("filt_early_valid", {31'd0, out_valid_o}, 32'd0);
      step();
    end
    checkOutput("filt_valid", {31'd0, out_valid_o}, 32'd1);
    checkOutput("filt_data", {24'd0, out_data_o}, 32'd50);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    checkOutput("filt_after_valid", {31'd0, out_valid_o}, 32'd0);
    checkOutput("filt_after_busy", {31'd0, busy_o}, 32'd0);

    // Backpressure: six results into a four-entry FIFO.
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(32'(2 * k), 1'b1, 1'b1);
      step();
    end
    applyStimulus(32'd0, 1'b0, 1'b0);
    step();
    step();
    step();
    step();
    checkOutput("bp_overflow", {31'd0, overflow_o}, 32'd1);
    checkOutput("bp_busy", {31'd0, busy_o}, 32'd1);
    out_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checkOutput("bp_drain_valid", {31'd0, out_valid_o}, 32'd1);
      checkOutput("bp_drain_data", {24'd0, out_data_o}, 32'(k));
      step();
    end
    checkOutput("bp_empty", {31'd0, out_valid_o}, 32'd0);
    checkOutput("bp_ovf_sticky", {31'd0, overflow_o}, 32'd1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checkOutput("bp_clear_ovf", {31'd0, overflow_o}, 32'd0);

    // Tile marking: tile of three, seven results streamed with ready high.
    cfg_tile_len_i = 16'd3;
    for (int c = 0; c <= 10; c++) begin
      if (c < 7) applyStimulus(32'(2 * (c + 1)), 1'b1, 1'b1);
      else       applyStimulus(32'd0, 1'b0, 1'b0);
      if (c >= 4) begin
        checkOutput("tile_valid", {31'd0, out_valid_o}, 32'd1);
        checkOutput("tile_data", {24'd0, out_data_o}, 32'(c - 3));
        checkOutput("tile_last", {31'd0, out_last_o}, {31'd0, (c == 6 || c == 9)});
      end else begin
        checkOutput("tile_wait_valid", {31'd0, out_valid_o}, 32'd0);
      end
      step();
    end

    // Park one result in the FIFO, then reset asynchronously mid-cycle.
    out_ready_i = 1'b0;
    applyStimulus(32'd20, 1'b1, 1'b1);
    step();
    applyStimulus(32'd0, 1'b0, 1'b0);
    step();
    step();
    step();
    checkOutput("prerst_valid", {31'd0, out_valid_o}, 32'd1);
    checkOutput("prerst_data", {24'd0, out_data_o}, 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", {31'd0, out_valid_o}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("arst_data", {24'd0, out_data_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Next tile after reset starts counting from zero.
    out_ready_i = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c < 3) applyStimulus(32'(2 * (c + 1)), 1'b1, 1'b1);
      else       applyStimulus(32'd0, 1'b0, 1'b0);
      if (c >= 4) begin
        checkOutput("rtile_data", {24'd0, out_data_o}, 32'(c - 3));
        checkOutput("rtile_last", {31'd0, out_last_o}, {31'd0, (c == 6)});
      end
      step();
    end
    checkOutput("rtile_idle", {31'd0, busy_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
